if_fetch_stage: RTL

Instruction-fetch stage sitting directly downstream of the PC register. Each cycle it:
- takes the current PC;
- issues an instruction-memory request;
- loads the returned word into the IF/ID pipeline register;
- drives the PC register's `enable`/`d` inputs with the next PC (sequential or redirected).

It absorbs decode stalls and memory wait states through a one-entry skid buffer and a two-state FSM.

---
 rtl/if_fetch_stage_pkg.sv | 22 ++
 rtl/if_skid_buffer.sv | 36 +++
 rtl/if_fetch_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions for the instruction-fetch stage: widths, constants,
// FSM encoding and the fetched-instruction payload.
package if_fetch_stage_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0]    PC_INC    = PC_W'(4);
    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0000);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched instruction that decode could not
// take yet. Falling-edge clocked to match the PC register.
module if_skid_buffer
    import if_fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [PC_W-1:0]    new_pc,
    input  logic [PC_W-1:0]    new_pc_plus4,
    input  logic [INSTR_W-1:0] new_instr,
    output logic               valid,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus4,
    output logic [INSTR_W-1:0] instr
);

    // Clear wins over load so a redirect always discards the held entry.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            pc       <= '0;
            pc_plus4 <= '0;
            instr    <= NOP_INSTR;
        end else if (clear) begin
            valid    <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            pc       <= new_pc;
            pc_plus4 <= new_pc_plus4;
            instr    <= new_instr;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the PC register and instruction memory,
// fills the IF/ID register and absorbs decode stalls through a skid buffer.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_INSTR
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_enable,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic [31:0] fetch_count
);

    fetch_state_e state, state_next;

    logic [PC_W-1:0] pc_plus4;
    logic            blocked;
    logic            ifid_load;
    logic            ifid_from_skid;
    logic            ifid_flush;
    logic            ifid_bubble;
    logic            skid_load;
    logic            skid_clear;
    logic            count_inc;
    logic            skid_valid;
    fetch_entry_t    skid;
    logic            unused_tgt_bits;

    assign pc_plus4        = pc + PC_INC;
    assign blocked         = stall & ifid_valid;
    assign unused_tgt_bits = ^redirect_target[1:0];

    // State register
    always_ff @(negedge clk or posedge reset) begin
        if (reset) state <= ST_FETCH;
        else       state <= state_next;
    end

    // Next state, PC mux, memory request and IF/ID control
    always_comb begin
        state_next     = state;
        pc_enable      = 1'b0;
        pc_next        = pc;
        imem_req       = 1'b0;
        imem_addr      = {pc[PC_W-1:2], 2'b00};
        ifid_load      = 1'b0;
        ifid_from_skid = 1'b0;
        ifid_flush     = 1'b0;
        ifid_bubble    = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        count_inc      = 1'b0;

        if (redirect) begin
            pc_enable  = 1'b1;
            pc_next    = {redirect_target[PC_W-1:2], 2'b00};
            ifid_flush = 1'b1;
            skid_clear = 1'b1;
            state_next = ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        pc_enable = 1'b1;
                        pc_next   = pc_plus4;
                        if (blocked) begin
                            skid_load  = 1'b1;
                            state_next = ST_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            count_inc = 1'b1;
                        end
                    end else if (!blocked) begin
                        // Decode consumed the old entry and nothing arrived.
                        ifid_bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_from_skid = skid_valid;
                        count_inc      = skid_valid;
                        skid_clear     = 1'b1;
                        state_next     = ST_FETCH;
                    end
                end
                default: state_next = ST_FETCH;
            endcase
        end

        // No request or PC write while reset is held.
        if (reset) begin
            imem_req  = 1'b0;
            pc_enable = 1'b0;
        end
    end

    if_skid_buffer u_skid (
        .clk          (clk),
        .reset        (reset),
        .load         (skid_load),
        .clear        (skid_clear),
        .new_pc       (pc),
        .new_pc_plus4 (pc_plus4),
        .new_instr    (imem_rdata),
        .valid        (skid_valid),
        .pc           (skid.pc),
        .pc_plus4     (skid.pc_plus4),
        .instr        (skid.instr)
    );

    // IF/ID pipeline register
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid    <= 1'b0;
            ifid_pc       <= RESET_PC;
            ifid_pc_plus4 <= RESET_PC + PC_INC;
            ifid_instr    <= NOP;
        end else if (ifid_flush) begin
            ifid_valid    <= 1'b0;
            ifid_instr    <= NOP;
        end else if (ifid_load) begin
            ifid_valid    <= 1'b1;
            ifid_pc       <= pc;
            ifid_pc_plus4 <= pc_plus4;
            ifid_instr    <= imem_rdata;
        end else if (ifid_from_skid) begin
            ifid_valid    <= 1'b1;
            ifid_pc       <= skid.pc;
            ifid_pc_plus4 <= skid.pc_plus4;
            ifid_instr    <= skid.instr;
        end else if (ifid_bubble) begin
            ifid_valid    <= 1'b0;
        end
    end

    // Delivered-instruction counter, wraps naturally
    always_ff @(negedge clk or posedge reset) begin
        if (reset)          fetch_count <= '0;
        else if (count_inc) fetch_count <= fetch_count + 32'd1;
    end

endmodule
